mem_result_checker: RTL

Parametrised end-of-run result checker for the rv32i core. It snoops the data-memory write port, shadows the last value written to each of NUM_CHECKS programmed addresses, and compares every slot against its expected value once the run ends. The run ends on a cycle timeout or an explicit halt. It generalises the single fixed-time "memory data equals 14" check to many slots with a programmable window. It sits beside `top`, so directed programs can be self-checking in simulation and on FPGA.

---
 rtl/mem_result_checker.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_result_checker.sv
// mem_result_checker
// End-of-run result checker for the rv32i core. It snoops the data-memory
// write port and shadows the last value written to each of NUM_CHECKS
// programmed addresses. When the run ends (timeout or halt), it walks the
// slots in ascending order and reports the first mismatch, or a pass.
// Optional feature macro: MEM_CHECK_EARLY_EXIT_EN. When it is defined, the
// run also ends as soon as every slot already holds its expected value.
module mem_result_checker #(
  parameter int NUM_CHECKS     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 34,
  parameter int IDXW           = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  parameter int CNTW           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDXW-1:0]       cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  obs_we,
  input  logic [ADDR_WIDTH-1:0] obs_addr,
  input  logic [DATA_WIDTH-1:0] obs_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [IDXW-1:0]       fail_idx,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [CNTW-1:0]       cycles
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] exp_addr_q [NUM_CHECKS];
  logic [ADDR_WIDTH-1:0] exp_addr_d [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] exp_data_q [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] exp_data_d [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] got_q [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] got_d [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] seen_q, seen_d;
  logic [IDXW-1:0]       chk_idx_q, chk_idx_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  pass_q, pass_d, fail_q, fail_d;
  logic [IDXW-1:0]       fail_idx_q, fail_idx_d;
  logic [DATA_WIDTH-1:0] fail_got_q, fail_got_d;
  logic [CNTW-1:0]       cycles_q, cycles_d;

  logic arm_s, timeout_s, slot_ok_s, last_slot_s, early_s, cfg_ok_s;

  assign arm_s       = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign timeout_s   = (cycles_q == CNTW'(TIMEOUT_CYCLES - 1));
  assign slot_ok_s   = seen_q[chk_idx_q] && (got_q[chk_idx_q] == exp_data_q[chk_idx_q]);
  assign last_slot_s = (chk_idx_q == IDXW'(NUM_CHECKS - 1));
  assign cfg_ok_s    = ({1'b0, cfg_idx} < (IDXW + 1)'(NUM_CHECKS));

`ifdef MEM_CHECK_EARLY_EXIT_EN
  logic all_match_q, all_match_d;

  // Registered flag: every slot already seen with its expected value
  always_comb begin
    all_match_d = (state_q == S_ARMED);
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (!seen_d[i] || (got_d[i] != exp_data_d[i])) begin
        all_match_d = 1'b0;
      end else begin
        all_match_d = all_match_d;
      end
    end
  end

  // All-match flag register
  always_ff @(posedge clk) begin
    if (rst) all_match_q <= 1'b0;
    else     all_match_q <= all_match_d;
  end

  assign early_s = all_match_q;
`else
  assign early_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ARMED; else state_d = S_IDLE;
      S_ARMED: if (halt || timeout_s || early_s) state_d = S_CHECK; else state_d = S_ARMED;
      S_CHECK: if (!slot_ok_s || last_slot_s) state_d = S_DONE; else state_d = S_CHECK;
      S_DONE:  if (start) state_d = S_ARMED; else state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Expected table writes (IDLE only) and shadow capture (ARMED only)
  always_comb begin
    seen_d = seen_q;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      exp_addr_d[i] = exp_addr_q[i];
      exp_data_d[i] = exp_data_q[i];
      got_d[i]      = got_q[i];
    end
    if ((state_q == S_IDLE) && cfg_we && cfg_ok_s) begin
      exp_addr_d[cfg_idx] = cfg_addr;
      exp_data_d[cfg_idx] = cfg_data;
    end else begin
      seen_d = seen_d;
    end
    if (arm_s) begin
      seen_d = '0;
      for (int i = 0; i < NUM_CHECKS; i++) got_d[i] = '0;
    end else if ((state_q == S_ARMED) && obs_we) begin
      // Duplicate watched addresses are all updated by the same write
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (exp_addr_q[i] == obs_addr) begin
          seen_d[i] = 1'b1;
          got_d[i]  = obs_data;
        end else begin
          seen_d[i] = seen_d[i];
        end
      end
    end else begin
      seen_d = seen_d;
    end
  end

  // Slot storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        exp_addr_q[i] <= '0;
        exp_data_q[i] <= '0;
        got_q[i]      <= '0;
      end
    end else begin
      seen_q <= seen_d;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        exp_addr_q[i] <= exp_addr_d[i];
        exp_data_q[i] <= exp_data_d[i];
        got_q[i]      <= got_d[i];
      end
    end
  end

  // Output and bookkeeping logic: cycle count, slot walk, verdict latch
  always_comb begin
    busy_d     = (state_d == S_ARMED) || (state_d == S_CHECK);
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;
    fail_got_d = fail_got_q;
    cycles_d   = cycles_q;
    chk_idx_d  = chk_idx_q;
    if (arm_s) begin
      done_d     = 1'b0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      fail_idx_d = '0;
      fail_got_d = '0;
      cycles_d   = '0;
      chk_idx_d  = '0;
    end else if (state_q == S_ARMED) begin
      cycles_d = cycles_q + CNTW'(1);
    end else if (state_q == S_CHECK) begin
      if (!slot_ok_s) begin
        done_d     = 1'b1;
        fail_d     = 1'b1;
        fail_idx_d = chk_idx_q;
        fail_got_d = got_q[chk_idx_q];
      end else if (last_slot_s) begin
        done_d = 1'b1;
        pass_d = 1'b1;
      end else begin
        chk_idx_d = chk_idx_q + IDXW'(1);
      end
    end else begin
      done_d = done_q;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
      cycles_q   <= '0;
      chk_idx_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      fail_got_q <= fail_got_d;
      cycles_q   <= cycles_d;
      chk_idx_q  <= chk_idx_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign fail_idx = fail_idx_q;
  assign fail_got = fail_got_q;
  assign cycles   = cycles_q;

endmodule
